key_expansion: RTL and testbench

KEY_EXPANSION -- requirements
Module: key_expansion

---
 rtl/key_expansion.sv | 115 +++++++++++
 tb/tb_key_expansion.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/key_expansion.sv
// AES-128 key schedule generator.
// One round key (four 32-bit words) is produced per clock after start is
// accepted, so the full 11-round schedule is ready ten cycles later. The
// schedule is held in a packed array whose element 0 is the most
// significant slice, which makes word_out a direct view of the registers.
module key_expansion #(
  parameter int Nb = 128,
  parameter int Nr = 10
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   start,
  input  logic [Nb-1:0]          round_key,
  output logic [Nb*(Nr+1)-1:0]   word_out,
  output logic                   busy,
  output logic                   done
);

  localparam logic [3:0] LAST_ROUND = 4'(Nr);

  // Forward AES S-box; element 0 is the leftmost byte of the literal.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [0:Nr][Nb-1:0] sched;
  logic [3:0]          round_cnt;
  logic [3:0]          prev_idx;
  logic [Nb-1:0]       prev_key;
  logic [Nb-1:0]       next_key;
  logic [31:0]         temp_word;
  logic [7:0]          rcon;

  assign word_out = sched;

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Round constant for the round currently being generated.
  always_comb begin
    rcon = 8'h00;
    case (round_cnt)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Derive the next round key from the previously stored round.
  always_comb begin
    prev_idx  = (round_cnt == 4'd0) ? 4'd0 : round_cnt - 4'd1;
    prev_key  = sched[prev_idx];
    temp_word = sub_word(rot_word(prev_key[31:0])) ^ {rcon, 24'h000000};
    next_key[127:96] = prev_key[127:96] ^ temp_word;
    next_key[95:64]  = prev_key[95:64]  ^ next_key[127:96];
    next_key[63:32]  = prev_key[63:32]  ^ next_key[95:64];
    next_key[31:0]   = prev_key[31:0]   ^ next_key[63:32];
  end

  // Accept start when idle, then fill one round slot per clock until done.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sched     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      round_cnt <= 4'd0;
    end else if (!busy) begin
      if (start) begin
        sched     <= '0;
        sched[0]  <= round_key;
        busy      <= 1'b1;
        done      <= 1'b0;
        round_cnt <= 4'd1;
      end
    end else begin
      sched[round_cnt] <= next_key;
      if (round_cnt == LAST_ROUND) begin
        busy      <= 1'b0;
        done      <= 1'b1;
        round_cnt <= 4'd0;
      end else begin
        round_cnt <= round_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_key_expansion.sv
// Directed testbench for key_expansion using FIPS-197 reference vectors.
module tb_key_expansion;

  logic          Clk;
  logic          Rst_n;
  logic          start;
  logic [127:0]  round_key;
  logic [1407:0] word_out;
  logic          busy;
  logic          done;

  int checks;
  int passed;
  int cycles;

  localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_A_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KEY_A_R2 = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] KEY_A_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_B    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_B_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] KEY_Z_R1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] KEY_Z_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  key_expansion #(.Nb(128), .Nr(10)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .start     (start),
    .round_key (round_key),
    .word_out  (word_out),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [127:0] round_of(input logic [1407:0] w, input int i);
    return w[1407 - 128*i -: 128];
  endfunction

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Wait on falling edges until done rises, bounded by a cycle budget.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 30) begin
      @(negedge Clk);
      n++;
    end
  endtask

  // Directed sequence.
  initial begin
    checks    = 0;
    passed    = 0;
    Rst_n     = 1'b0;
    start     = 1'b0;
    round_key = '0;

    #1;
    check_output("reset_word_out_pre_clk", 128'(|word_out), 128'd0);
    check_output("reset_busy_pre_clk", 128'(busy), 128'd0);
    check_output("reset_done_pre_clk", 128'(done), 128'd0);

    repeat (2) @(negedge Clk);
    check_output("reset_word_out", 128'(|word_out), 128'd0);
    check_output("reset_done", 128'(done), 128'd0);

    // Release reset with start already high: the first edge accepts it.
    Rst_n     = 1'b1;
    start     = 1'b1;
    round_key = KEY_A;
    @(negedge Clk);
    start     = 1'b0;
    round_key = KEY_B;
    check_output("a_busy_after_start", 128'(busy), 128'd1);
    check_output("a_done_after_start", 128'(done), 128'd0);
    check_output("a_round0_loaded", round_of(word_out, 0), KEY_A);
    check_output("a_round10_cleared", round_of(word_out, 10), 128'd0);
    wait_done(cycles);
    check_output("a_latency", 128'(cycles), 128'd10);
    check_output("a_busy_at_done", 128'(busy), 128'd0);
    check_output("a_round0", round_of(word_out, 0), KEY_A);
    check_output("a_round1", round_of(word_out, 1), KEY_A_R1);
    check_output("a_round2", round_of(word_out, 2), KEY_A_R2);
    check_output("a_round10", round_of(word_out, 10), KEY_A_R10);

    // Result and done must hold while idle.
    repeat (3) @(negedge Clk);
    check_output("a_done_hold", 128'(done), 128'd1);
    check_output("a_round10_hold", round_of(word_out, 10), KEY_A_R10);

    // Second key vector.
    start     = 1'b1;
    round_key = KEY_B;
    @(negedge Clk);
    start = 1'b0;
    wait_done(cycles);
    check_output("b_latency", 128'(cycles), 128'd10);
    check_output("b_round0", round_of(word_out, 0), KEY_B);
    check_output("b_round10", round_of(word_out, 10), KEY_B_R10);

    // Start pulse with a new key mid-expansion is ignored.
    start     = 1'b1;
    round_key = KEY_A;
    @(negedge Clk);
    start  = 1'b0;
    cycles = 0;
    while (done !== 1'b1 && cycles < 30) begin
      @(negedge Clk);
      cycles++;
      if (cycles == 3) begin
        start     = 1'b1;
        round_key = '0;
      end else if (cycles == 4) begin
        start = 1'b0;
      end
    end
    check_output("c_latency", 128'(cycles), 128'd10);
    check_output("c_round1", round_of(word_out, 1), KEY_A_R1);
    check_output("c_round10", round_of(word_out, 10), KEY_A_R10);

    // Reset mid-expansion clears everything at once.
    start     = 1'b1;
    round_key = KEY_B;
    @(negedge Clk);
    start = 1'b0;
    repeat (5) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check_output("d_reset_word_out", 128'(|word_out), 128'd0);
    check_output("d_reset_busy", 128'(busy), 128'd0);
    check_output("d_reset_done", 128'(done), 128'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    check_output("d_idle_busy", 128'(busy), 128'd0);
    check_output("d_idle_done", 128'(done), 128'd0);

    // All-zero key after the aborted run.
    start     = 1'b1;
    round_key = '0;
    @(negedge Clk);
    start = 1'b0;
    wait_done(cycles);
    check_output("z_latency", 128'(cycles), 128'd10);
    check_output("z_round1", round_of(word_out, 1), KEY_Z_R1);
    check_output("z_round10", round_of(word_out, 10), KEY_Z_R10);

    // Start held high: key change mid-run ignored, restart after done uses current key.
    start     = 1'b1;
    round_key = KEY_B;
    @(negedge Clk);
    round_key = KEY_A;
    wait_done(cycles);
    check_output("h_latency", 128'(cycles), 128'd10);
    check_output("h_round10", round_of(word_out, 10), KEY_B_R10);
    @(negedge Clk);
    start = 1'b0;
    check_output("h_restart_busy", 128'(busy), 128'd1);
    check_output("h_restart_done", 128'(done), 128'd0);
    check_output("h_restart_round0", round_of(word_out, 0), KEY_A);
    check_output("h_restart_round10", round_of(word_out, 10), 128'd0);
    wait_done(cycles);
    check_output("h2_latency", 128'(cycles), 128'd10);
    check_output("h2_round10", round_of(word_out, 10), KEY_A_R10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
